count_sequencer: RTL and testbench
==================================

# count_sequencer

Command-driven controller for the prescaled event counter datapath: a programmable prescaler and an up-counter, sequenced by a four-state machine (IDLE, RUN, PAUSED, DONE). It sits between the host command interface and the counter. It accepts START/STOP/PAUSE/RESUME commands over a valid/ready handshake and latches the prescale divisor and terminal count at START. It emits registered tick and done pulses for downstream logic.

## Interface
- PRESCALE_W, 26, width of prescaler and divisor
- COUNT_W, 8, width of counter and target
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 START, 01 STOP, 10 PAUSE, 11 RESUME
- cfg_div  in  PRESCALE_W  prescaler terminal value; one count per cfg_div+1 cycles; sampled only on accepted START
- cfg_target  in  COUNT_W  terminal count; sampled only on accepted START
- count  out  COUNT_W  current count, registered
- tick  out  1  one-cycle pulse, high in the cycle count updates
- done  out  1  one-cycle pulse on reaching target
- busy  out  1  state is RUN or PAUSED
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3

## Operation
- Reset (rst low, async): state=IDLE, count=0, prescaler=0, div_q=0, target_q=0, tick=0, done=0, busy=0. cmd_ready=0 while rst is low, 1 otherwise.
- Accepted START, any state:
  - div_q<=cfg_div, target_q<=cfg_target, count<=0, prescaler<=0, state<=RUN.
  - START in RUN, PAUSED or DONE is a restart.
- IDLE: prescaler and count held. STOP, PAUSE and RESUME are accepted and have no effect.
- RUN, no command:
  - If prescaler!=div_q: prescaler<=prescaler+1.
  - If prescaler==div_q: prescaler<=0, count<=count+1 (mod 2^COUNT_W), tick<=1.
  - If count+1 (mod 2^COUNT_W)==target_q: done<=1 and terminal handling (see Configuration).
- target_q=0 means terminal after wrap, i.e. 2^COUNT_W ticks. div_q=0 gives a tick every cycle.
- PAUSE in RUN: state<=PAUSED; prescaler and count frozen. Ignored in other states.
- RESUME in PAUSED: state<=RUN; prescaler continues from its frozen value. Ignored in other states.
- STOP in RUN, PAUSED or DONE: state<=IDLE, prescaler<=0, count held.
- DONE: count holds target_q, prescaler held at 0. Exited only by START or STOP.
- Simultaneous command and terminal prescaler cycle: the command wins.
  - The tick is suppressed that cycle; prescaler is not advanced unless the command reloads it.

## Timing
- All outputs registered except cmd_ready (constant 1 out of reset).
- START accepted at edge E0: state=RUN after E0.
  - First tick/count=1 after edge E0+div_q+1.
  - Subsequent ticks every div_q+1 cycles.
- tick and done are high for exactly one cycle, coincident with the count update.
- done rises in the same cycle count shows target_q (count shows 0 with autoreload).
- State changes from commands are visible one cycle after acceptance.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge.

## Configuration
- COUNT_SEQ_AUTORELOAD_EN defined:
  - On the terminal tick, count<=0, prescaler<=0, done<=1, state stays RUN.
  - Counting repeats until STOP, PAUSE or START.
  - DONE is unreachable.
- COUNT_SEQ_AUTORELOAD_EN undefined:
  - On the terminal tick, count<=target_q, done<=1, state<=DONE.

## Test plan
- Reset, then START with div=9, target=3: tick at cycles 10, 20, 30 after acceptance; count 1, 2, 3; done with the third tick; state=DONE (no macro) and count held at 3 for 50 further cycles.
- Same run with COUNT_SEQ_AUTORELOAD_EN: count sequence 1, 2, 0, 1, 2, 0; done pulses every 30 cycles; state stays RUN.
- START div=0, target=0: tick every cycle; done after 256 ticks with count=0 (wrap).
- START div=9, PAUSE after 15 cycles: count=1, held for 100 cycles. RESUME: next tick exactly 5 cycles later, count=2.
- START div=4: STOP presented on the terminal prescaler cycle gives no tick, state=IDLE, count unchanged. START while RUN at count=2 restarts count=0 with newly sampled cfg_div/cfg_target.
- Assert rst mid-RUN between clock edges: count, state, tick, done and busy are 0 immediately. cmd_ready is 0 until rst deasserts.

Source files
------------

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//
// Command-driven controller for a prescaled event counter. A host issues
// START / STOP / PAUSE / RESUME over a valid/ready handshake. START latches
// the prescale divisor and the terminal count, then the block counts one event
// every (div+1) clock cycles until the terminal count is reached.
//
// Optional feature (compile-time macro):
//   COUNT_SEQ_AUTORELOAD_EN
//     undefined : on the terminal tick the count holds the target value and
//                 the machine parks in DONE until START or STOP.
//     defined   : on the terminal tick the count and prescaler restart from
//                 zero and the machine stays in RUN (DONE is unreachable).
//
// Parameters:
//   PRESCALE_W   width of the prescaler and of the divisor
//   COUNT_W      width of the counter and of the target
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   cmd_valid_i   command present
//   cmd_ready_o   command accepted when cmd_valid_i && cmd_ready_o
//                 (low only while reset is asserted)
//   cmd_op_i      00 START, 01 STOP, 10 PAUSE, 11 RESUME
//   cfg_div_i     prescaler terminal value, sampled on accepted START
//   cfg_target_i  terminal count, sampled on accepted START
//   count_o       current count (registered)
//   tick_o        one-cycle pulse, high in the cycle the count updates
//   done_o        one-cycle pulse on reaching the target
//   busy_o        state is RUN or PAUSED
//   state_o       IDLE=0, RUN=1, PAUSED=2, DONE=3
// -----------------------------------------------------------------------------
module count_sequencer #(
  parameter int PRESCALE_W = 26,
  parameter int COUNT_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [PRESCALE_W-1:0] cfg_div_i,
  input  logic [COUNT_W-1:0]    cfg_target_i,
  output logic [COUNT_W-1:0]    count_o,
  output logic                  tick_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_PAUSE  = 2'd2,
    OP_RESUME = 2'd3
  } op_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                  state_q,  state_d;
  logic [PRESCALE_W-1:0]   presc_q,  presc_d;
  logic [PRESCALE_W-1:0]   div_q,    div_d;
  logic [COUNT_W-1:0]      count_q,  count_d;
  logic [COUNT_W-1:0]      target_q, target_d;
  logic                    tick_q,   tick_d;
  logic                    done_q,   done_d;
  logic                    busy_q,   busy_d;

  logic                    cmd_accept;
  logic                    presc_term;
  logic [COUNT_W-1:0]      count_inc;

  // The block can take a command every cycle once out of reset, so the
  // ready flag is simply the reset deassertion itself.
  assign cmd_ready_o = rst_ni;
  assign cmd_accept  = cmd_valid_i & cmd_ready_o;

  // Terminal prescaler cycle: the count advances on this cycle.
  assign presc_term  = (presc_q == div_q);

  // Natural wrap at 2^COUNT_W; a target of zero therefore terminates after
  // a full wrap of the counter.
  assign count_inc   = count_q + COUNT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    div_d    = div_q;
    count_d  = count_q;
    target_d = target_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    if (cmd_accept) begin
      // A command always takes priority over counting in the same cycle:
      // no tick is produced and the prescaler only moves if reloaded.
      unique case (op_e'(cmd_op_i))
        OP_START: begin
          div_d    = cfg_div_i;
          target_d = cfg_target_i;
          count_d  = '0;
          presc_d  = '0;
          state_d  = ST_RUN;
        end
        OP_STOP: begin
          if (state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
          end
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSED) begin
            state_d = ST_RUN;
          end
        end
      endcase
    end else if (state_q == ST_RUN) begin
      if (presc_term) begin
        presc_d = '0;
        count_d = count_inc;
        tick_d  = 1'b1;
        if (count_inc == target_q) begin
          done_d = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
          count_d = '0;
`else
          count_d = target_q;
          state_d = ST_DONE;
`endif
        end
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      div_q    <= '0;
      count_q  <= '0;
      target_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      div_q    <= div_d;
      count_q  <= count_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int PW   = 26;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  localparam logic [1:0] START  = 2'b00;
  localparam logic [1:0] STOP   = 2'b01;
  localparam logic [1:0] PAUSE  = 2'b10;
  localparam logic [1:0] RESUME = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [PW-1:0] cfg_div = '0;
  logic [CW-1:0] cfg_target = '0;
  logic [CW-1:0] count;
  logic          tick, done, busy;
  logic [1:0]    state;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: state as a small integer, elapsed cycles within the
  // current count period, and the count kept modulo 2^CW.
  int m_state, m_elapsed, m_div, m_target, m_count;
  bit m_tick, m_done;

  count_sequencer #(.PRESCALE_W(PW), .COUNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cfg_div_i(cfg_div), .cfg_target_i(cfg_target),
    .count_o(count), .tick_o(tick), .done_o(done), .busy_o(busy), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_div = 0; m_target = 0; m_count = 0;
    m_tick = 0; m_done = 0;
  endtask

  task automatic model_edge(bit acc, logic [1:0] op, int div, int tgt);
    m_tick = 0;
    m_done = 0;
    if (acc) begin
      case (op)
        START:  begin m_div = div; m_target = tgt; m_count = 0; m_elapsed = 0; m_state = 1; end
        STOP:   if (m_state != 0) begin m_state = 0; m_elapsed = 0; end
        PAUSE:  if (m_state == 1) m_state = 2;
        RESUME: if (m_state == 2) m_state = 1;
        default: ;
      endcase
    end else if (m_state == 1) begin
      m_elapsed++;
      if (m_elapsed == m_div + 1) begin
        m_elapsed = 0;
        m_tick    = 1;
        m_count   = (m_count + 1) % CMOD;
        if (m_count == m_target) begin
          m_done = 1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
          m_count = 0;
`else
          m_state = 3;
`endif
        end
      end
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".tick"},  32'(tick),  32'(m_tick));
    chk({tag, ".done"},  32'(done),  32'(m_done));
    chk({tag, ".busy"},  32'(busy),  32'((m_state == 1) || (m_state == 2)));
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(rst_n));
  endtask

  // One clock: present inputs, let the edge happen, advance the model,
  // then compare 1 time unit after the edge.
  task automatic step(string tag, bit v, logic [1:0] op, int div, int tgt);
    cmd_valid  = v;
    cmd_op     = op;
    cfg_div    = PW'(div);
    cfg_target = CW'(tgt);
    @(posedge clk);
    model_edge(v && rst_n, op, div, tgt);
    #1;
    check_outputs(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, START, 0, 0);
  endtask

  initial begin
    model_reset();

    // Reset state
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("reset_release");

    // START div=9 target=3: ticks 10, 20, 30 cycles after acceptance
    step("t1_start", 1'b1, START, 9, 3);
    idle("t1_wait", 9);
    step("t1_tick1", 1'b0, START, 0, 0);
    chk("t1_tick1_seen", 32'(tick), 32'd1);
    chk("t1_count1", 32'(count), 32'd1);
    idle("t1_wait", 9);
    step("t1_tick2", 1'b0, START, 0, 0);
    chk("t1_count2", 32'(count), 32'd2);
    idle("t1_wait", 9);
    step("t1_tick3", 1'b0, START, 0, 0);
    chk("t1_done3", 32'(done), 32'd1);
`ifdef COUNT_SEQ_AUTORELOAD_EN
    chk("t1_count3", 32'(count), 32'd0);
    chk("t1_state3", 32'(state), 32'd1);
    idle("t1_reload", 60);
    chk("t1_reload_count", 32'(count), 32'd0);
`else
    chk("t1_count3", 32'(count), 32'd3);
    chk("t1_state3", 32'(state), 32'd3);
    idle("t1_hold", 50);
    chk("t1_hold_count", 32'(count), 32'd3);
    chk("t1_hold_state", 32'(state), 32'd3);
`endif

    // START div=0 target=0: tick every cycle, done after 256 ticks
    step("t2_start", 1'b1, START, 0, 0);
    idle("t2_run", 255);
    chk("t2_no_early_done", 32'(done), 32'd0);
    step("t2_wrap", 1'b0, START, 0, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd0);

    // PAUSE / RESUME: next tick exactly 5 cycles after RESUME
    step("t3_start", 1'b1, START, 9, 0);
    idle("t3_run", 15);
    step("t3_pause", 1'b1, PAUSE, 0, 0);
    idle("t3_hold", 100);
    chk("t3_held_count", 32'(count), 32'd1);
    chk("t3_held_state", 32'(state), 32'd2);
    step("t3_resume", 1'b1, RESUME, 0, 0);
    idle("t3_after", 4);
    chk("t3_no_early_tick", 32'(count), 32'd1);
    step("t3_tick", 1'b0, START, 0, 0);
    chk("t3_tick_seen", 32'(tick), 32'd1);
    chk("t3_count2", 32'(count), 32'd2);

    // STOP on the terminal prescaler cycle wins over the tick
    step("t4_start", 1'b1, START, 4, 9);
    idle("t4_run", 14);
    step("t4_stop", 1'b1, STOP, 0, 0);
    chk("t4_no_tick", 32'(tick), 32'd0);
    chk("t4_idle", 32'(state), 32'd0);
    chk("t4_count_kept", 32'(count), 32'd2);
    idle("t4_idle", 8);

    // START while RUN restarts with new configuration
    step("t5_start", 1'b1, START, 4, 9);
    idle("t5_run", 10);
    chk("t5_count2", 32'(count), 32'd2);
    step("t5_restart", 1'b1, START, 7, 5);
    chk("t5_count0", 32'(count), 32'd0);
    idle("t5_wait", 7);
    step("t5_tick", 1'b0, START, 0, 0);
    chk("t5_new_div_tick", 32'(tick), 32'd1);

    // Asynchronous reset between clock edges
    step("t6_start", 1'b1, START, 2, 50);
    idle("t6_run", 7);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_async_reset");
    @(posedge clk);
    #1;
    check_outputs("t6_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("t6_release");

    // Randomized commands against the model
    for (int i = 0; i < 1500; i++) begin
      bit v;
      logic [1:0] op;
      v  = ($urandom_range(0, 5) == 0);
      op = 2'($urandom_range(0, 3));
      step("rand", v, op, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
